// File: rtl/playback_pkg.sv
// Shared types and widths for the playback sample feeder.
// Used by playback_sample_feeder and interp_div.
package playback_pkg;

    localparam int ADDR_W   = 20;
    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_PLAY,
        S_PAUSE
    } state_t;

    typedef enum logic [1:0] {
        NORMAL,
        FAST,
        SLOW
    } speed_t;

    typedef enum logic [2:0] {
        F_IDLE,
        F_S0,
        F_S1,
        F_CALC,
        F_DIV
    } fetch_t;

    // A factor of 1 is normal speed whatever the mode bits say.
    function automatic speed_t speed_mode(
        input logic       fast,
        input logic       slow,
        input logic [2:0] speed
    );
        if (speed == 3'd0) return NORMAL;
        if (fast)          return FAST;
        if (slow)          return SLOW;
        return NORMAL;
    endfunction

endpackage

// File: rtl/playback_sample_feeder_div.sv
// interp_div: signed-numerator restoring divider, one quotient bit per cycle.
// Divisor is an unsigned speed factor 1..8, so only the numerator carries sign.
module interp_div
    import playback_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic signed [19:0]  i_num,
    input  logic [3:0]          i_den,
    output logic                o_done,
    output logic [SAMPLE_W-1:0] o_quo
);

    logic        r_busy;
    logic        r_neg;
    logic        r_done;
    logic [4:0]  r_cnt;
    logic [19:0] r_q;
    logic [3:0]  r_rem;
    logic [3:0]  r_den;
    logic [4:0]  w_shift;
    logic        w_ge;

    assign w_shift = {r_rem, r_q[19]};
    assign w_ge    = (w_shift >= {1'b0, r_den});

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= 1'b0;
            r_neg  <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
            r_q    <= '0;
            r_rem  <= '0;
            r_den  <= 4'd1;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_q    <= i_num[19] ? -i_num : i_num;
                r_neg  <= i_num[19];
                r_rem  <= '0;
                r_den  <= i_den;
                r_cnt  <= 5'd20;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_ge ? 4'(w_shift - {1'b0, r_den})
                              : w_shift[3:0];
                r_q   <= {r_q[18:0], w_ge};
                r_cnt <= r_cnt - 5'd1;
                if (r_cnt == 5'd1) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    // Quotient magnitude stays below 2^16, so the low bits are exact mod 2^16.
    assign o_done = r_done;
    assign o_quo  = r_neg ? -r_q[15:0] : r_q[15:0];

endmodule

// File: rtl/playback_sample_feeder.sv
// SRAM playback source feeding the DAC serializer, one sample per LRCK frame.
// Define PLAYBACK_INTERP_EN for linear interpolation in slow mode.
module playback_sample_feeder
    import playback_pkg::*;
(
    input  logic                i_BCLK,
    input  logic                i_rst,
    input  logic                i_DACLRCK,
    input  logic                i_start,
    input  logic                i_pause,
    input  logic                i_stop,
    input  logic                i_fast,
    input  logic                i_slow,
    input  logic [2:0]          i_speed,
    input  logic [ADDR_W-1:0]   i_end_addr,
    output logic [ADDR_W-1:0]   o_SRAM_ADDR,
    input  logic [SAMPLE_W-1:0] i_SRAM_DQ,
    output logic [SAMPLE_W-1:0] o_DATA,
    output logic                o_valid,
    output logic                o_done
);

    state_t              r_state, w_state_nxt;
    fetch_t              r_fph;
    speed_t              r_mode, w_mode;
    logic                r_pre_lrck, r_valid, r_done;
    logic [ADDR_W-1:0]   r_addr, w_addr1;
    logic [SAMPLE_W-1:0] r_s0, r_stage, r_data;
    logic [2:0]          r_k, w_k_nxt;
    logic [3:0]          r_n, w_n, w_k_inc, w_stride;
    logic [ADDR_W:0]     w_addr_nxt;
    logic                w_rise, w_play, w_chg;
    logic                w_adv, w_over, w_start;

    assign w_rise = ~r_pre_lrck & i_DACLRCK;
    assign w_play = w_rise && (r_state == S_PLAY)
                    && !i_stop && !i_pause;

    assign w_n     = {1'b0, i_speed} + 4'd1;
    assign w_mode  = speed_mode(i_fast, i_slow, i_speed);
    assign w_chg   = (w_mode != r_mode) || (w_n != r_n);
    assign w_k_inc = {1'b0, r_k} + 4'd1;
    assign w_k_nxt = (w_mode == SLOW && !w_chg && w_k_inc < w_n)
                     ? w_k_inc[2:0] : 3'd0;
    assign w_adv   = (w_k_nxt == 3'd0);

    assign w_stride   = (w_mode == FAST) ? w_n : 4'd1;
    assign w_addr_nxt = {1'b0, r_addr} + {17'd0, w_stride};
    assign w_over     = w_adv && (w_addr_nxt > {1'b0, i_end_addr});
    assign w_addr1    = (r_addr >= i_end_addr) ? r_addr
                                               : r_addr + 20'd1;
    assign w_start    = (r_state == S_IDLE) && (w_state_nxt == S_PRIME);

`ifdef PLAYBACK_INTERP_EN
    logic [SAMPLE_W-1:0] r_s1;
    logic [SAMPLE_W-1:0] w_quo;
    logic signed [19:0]  w_diff, w_kx, w_prod;
    logic                w_div_go, w_div_done;

    assign w_diff   = {{4{r_s1[15]}}, r_s1} - {{4{r_s0[15]}}, r_s0};
    assign w_kx     = {17'd0, r_k};
    assign w_prod   = w_diff * w_kx;
    assign w_div_go = (r_fph == F_CALC) && (r_k != 3'd0);

    interp_div u_div (
        .i_clk   (i_BCLK),
        .i_rst   (i_rst),
        .i_start (w_div_go),
        .i_num   (w_prod),
        .i_den   (r_n),
        .o_done  (w_div_done),
        .o_quo   (w_quo)
    );
`endif

    always_ff @(posedge i_BCLK) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (i_start && !i_pause) w_state_nxt = S_PRIME;
            S_PRIME: if (r_fph == F_CALC)     w_state_nxt = S_PLAY;
            S_PLAY: begin
                if (i_pause)              w_state_nxt = S_PAUSE;
                else if (w_play && w_over) w_state_nxt = S_IDLE;
            end
            S_PAUSE: if (i_start && !i_pause) w_state_nxt = S_PLAY;
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_stop) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge i_BCLK) begin
        if (i_rst) begin
            r_pre_lrck <= 1'b0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_addr     <= '0;
            r_k        <= '0;
            r_n        <= 4'd1;
            r_mode     <= NORMAL;
            r_fph      <= F_IDLE;
            r_s0       <= '0;
            r_stage    <= '0;
            r_data     <= '0;
`ifdef PLAYBACK_INTERP_EN
            r_s1       <= '0;
`endif
        end else begin
            r_pre_lrck <= i_DACLRCK;
            r_valid    <= 1'b1;
            r_done     <= w_play && w_over;
            if (w_rise) r_data <= w_play ? r_stage : '0;

            // Stage the next frame's sample: s0, s1, then hold or interpolate.
            unique case (r_fph)
                F_S0: begin
                    r_s0  <= i_SRAM_DQ;
                    r_fph <= F_S1;
                end
                F_S1: begin
`ifdef PLAYBACK_INTERP_EN
                    r_s1  <= i_SRAM_DQ;
`endif
                    r_fph <= F_CALC;
                end
                F_CALC: begin
`ifdef PLAYBACK_INTERP_EN
                    if (w_div_go) begin
                        r_fph <= F_DIV;
                    end else begin
                        r_stage <= r_s0;
                        r_fph   <= F_IDLE;
                    end
`else
                    r_stage <= r_s0;
                    r_fph   <= F_IDLE;
`endif
                end
                F_DIV: begin
`ifdef PLAYBACK_INTERP_EN
                    if (w_div_done) begin
                        r_stage <= r_s0 + w_quo;
                        r_fph   <= F_IDLE;
                    end
`else
                    r_fph <= F_IDLE;
`endif
                end
                default: ;
            endcase

            if (w_start) begin
                r_addr <= '0;
                r_k    <= '0;
                r_mode <= w_mode;
                r_n    <= w_n;
                r_fph  <= F_S0;
            end

            if (w_play) begin
                r_k    <= w_k_nxt;
                r_mode <= w_mode;
                r_n    <= w_n;
                if (w_over) begin
                    r_addr <= '0;
                end else if (w_adv) begin
                    r_addr <= w_addr_nxt[ADDR_W-1:0];
                    r_fph  <= F_S0;
                end else begin
                    r_fph  <= F_CALC;
                end
            end

            if (i_stop) r_addr <= '0;
        end
    end

    assign o_SRAM_ADDR = (r_fph == F_S1) ? w_addr1 : r_addr;
    assign o_DATA      = r_data;
    assign o_valid     = r_valid;
    assign o_done      = r_done;

endmodule

// File: tb/tb_playback_sample_feeder.sv
// Bench for playback_sample_feeder: random tracks against a frame-level model.
// Follows PLAYBACK_INTERP_EN to pick the hold or interpolating expectation.
module tb_playback_sample_feeder;

    logic        clk = 1'b0;
    logic        rst, lrck, start, pause, stop, fast, slow;
    logic [2:0]  speed;
    logic [19:0] end_addr, sram_addr;
    logic [15:0] dq, data;
    logic        valid, done;
    logic [15:0] mem [64];

    int total = 0;
    int bad = 0;
    int n_done = 0;

    always #5 clk = ~clk;

    assign dq = mem[sram_addr[5:0]];

    playback_sample_feeder dut (
        .i_BCLK      (clk),
        .i_rst       (rst),
        .i_DACLRCK   (lrck),
        .i_start     (start),
        .i_pause     (pause),
        .i_stop      (stop),
        .i_fast      (fast),
        .i_slow      (slow),
        .i_speed     (speed),
        .i_end_addr  (end_addr),
        .o_SRAM_ADDR (sram_addr),
        .i_SRAM_DQ   (dq),
        .o_DATA      (data),
        .o_valid     (valid),
        .o_done      (done)
    );

    initial begin
        lrck = 1'b0;
        forever begin
            repeat (32) @(posedge clk);
            #1 lrck = ~lrck;
        end
    end

    always @(negedge clk) if (done) n_done++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: still running at %0t, limit 1000000", $time);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns just after the clock edge that acts on an LRCK rise.
    task automatic wait_rise();
        @(posedge lrck);
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic st, input logic pa, input logic sp);
        @(negedge clk);
        start = st;
        pause = pa;
        stop  = sp;
        @(negedge clk);
        start = 1'b0;
        pause = 1'b0;
        stop  = 1'b0;
    endtask

    function automatic int stage_val(int a, int k, int n, int e);
        int s0, s1;
        s0 = int'($signed(mem[a]));
        s1 = int'($signed(mem[(a + 1 > e) ? a : a + 1]));
`ifdef PLAYBACK_INTERP_EN
        return s0 + ((s1 - s0) * k) / n;
`else
        return s0 + 0 * (s1 + k + n);
`endif
    endfunction

    task automatic set_mode(input logic f, input logic s,
                            input logic [2:0] sp, input int e);
        fast     = f;
        slow     = s;
        speed    = sp;
        end_addr = 20'(e);
    endtask

    // Plays one whole track from address 0 and checks every frame.
    task automatic run_track(input logic f, input logic s,
                             input logic [2:0] sp, input int e,
                             input string tag);
        int  a, k, n, stride, d0;
        bit  fm, sm, fin;
        logic [15:0] exp;
        n = int'(sp) + 1;
        fm = f && n > 1;
        sm = s && !f && n > 1;
        stride = fm ? n : 1;
        set_mode(f, s, sp, e);
        wait_rise();
        repeat (3) @(negedge clk);
        pulse(1'b1, 1'b0, 1'b0);
        d0 = n_done;
        a = 0;
        k = 0;
        fin = 0;
        while (!fin) begin
            exp = 16'(stage_val(a, k, n, e));
            if (sm) k = (k + 1) % n;
            if (!sm || k == 0) begin
                a += stride;
                if (a > e) fin = 1;
            end
            wait_rise();
            check({tag, ":data"}, data, exp);
            check({tag, ":done"}, done, fin);
            settle();
            check({tag, ":addr"}, sram_addr, fin ? 0 : a);
        end
        wait_rise();
        check({tag, ":idle_data"}, data, 0);
        check({tag, ":done_cnt"}, n_done - d0, 1);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        stop = 1'b0;
        set_mode(1'b0, 1'b0, 3'd0, 3);
        for (int i = 0; i < 64; i++) mem[i] = 16'(i * 10);
        repeat (3) @(posedge clk);
        #1;
        check("rst:data", data, 0);
        check("rst:valid", valid, 0);
        check("rst:done", done, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;
        check("post_rst:valid", valid, 1);
        check("post_rst:data", data, 0);
        check("post_rst:addr", sram_addr, 0);

        run_track(1'b0, 1'b0, 3'd0, 3, "normal");
        run_track(1'b1, 1'b0, 3'd1, 6, "fast2");

        mem[0] = 16'd100;
        mem[1] = 16'd500;
        run_track(1'b0, 1'b1, 3'd3, 1, "slow4");
        mem[0] = 16'd0;
        mem[1] = 16'hFFF9;
        run_track(1'b0, 1'b1, 3'd1, 1, "slow_neg");
        for (int i = 0; i < 64; i++) mem[i] = 16'(i * 10);

        set_mode(1'b0, 1'b0, 3'd0, 20);
        wait_rise();
        repeat (3) @(negedge clk);
        pulse(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            wait_rise();
            check("pause:pre", data, i * 10);
        end
        repeat (10) @(negedge clk);
        pulse(1'b0, 1'b1, 1'b0);
        wait_rise();
        check("pause:data", data, 0);
        settle();
        check("pause:addr", sram_addr, 3);
        wait_rise();
        check("pause:hold", data, 0);
        repeat (5) @(negedge clk);
        pulse(1'b1, 1'b0, 1'b0);
        wait_rise();
        check("resume:a3", data, 30);
        wait_rise();
        check("resume:a4", data, 40);
        repeat (5) @(negedge clk);
        pulse(1'b0, 1'b0, 1'b1);
        wait_rise();
        check("stop:data", data, 0);

        pulse(1'b1, 1'b0, 1'b0);
        wait_rise();
        check("ss:a0", data, 0);
        wait_rise();
        check("ss:a1", data, 10);
        repeat (10) @(negedge clk);
        pulse(1'b1, 1'b0, 1'b1);
        wait_rise();
        check("ss:data", data, 0);
        settle();
        check("ss:addr", sram_addr, 0);
        wait_rise();
        check("ss:idle", data, 0);

        pulse(1'b1, 1'b0, 1'b0);
        wait_rise();
        wait_rise();
        check("mid:a1", data, 10);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk) #1;
        check("mid_rst:data", data, 0);
        check("mid_rst:valid", valid, 0);
        check("mid_rst:done", done, 0);
        check("mid_rst:addr", sram_addr, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;
        check("mid_rst:valid1", valid, 1);
        run_track(1'b0, 1'b0, 3'd0, 4, "restart");

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
            run_track(1'($urandom_range(1)), 1'($urandom_range(1)),
                      3'($urandom_range(7)), int'($urandom_range(5)),
                      $sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
